dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the multicycle MIPS core's Memory stage and the backing data RAM.
- Consumes the core's address, data, r_en and w_en outputs; returns read data and a stall flag.
- Each line holds one 32-bit word.
- Line fills and evictions use a req/ack handshake to backing memory, so memory latency is variable.

Parameters:
- ADDR_W, 12, word-address width from the core.
- INDEX_W, 4, index bits; the cache has 2^INDEX_W lines. Tag width = ADDR_W-INDEX_W.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_W  word address from the core.
- cpu_wdata  in  32  store data from the core.
- cpu_rd  in  1  load request (level, sampled at clk edge).
- cpu_wr  in  1  store request (level, sampled at clk edge).
- cpu_rdata  out  32  load result, registered.
- stall  out  1  registered; high while a miss is being serviced.
- mem_addr  out  ADDR_W  backing memory word address.
- mem_wdata  out  32  eviction data.
- mem_rd  out  1  fill request; held until mem_ack.
- mem_wr  out  1  write-back request; held until mem_ack.
- mem_rdata  in  32  fill data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse from backing memory.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Address split: index = cpu_addr[INDEX_W-1:0]; tag = cpu_addr[ADDR_W-1:INDEX_W].
- Per-line storage: valid, dirty, tag, data.
- Reset (async, any state): state=IDLE.
  - All valid and dirty bits cleared.
  - stall, mem_rd and mem_wr go to 0 immediately.
  - cpu_rdata, mem_addr, mem_wdata, hit_count and miss_count go to 0.
  - Tag and data arrays need no reset.
- Request: cpu_rd or cpu_wr high at a clk edge while state=IDLE. If both are high, the request is a store. Requests are ignored in all other states.

FSM states:
- IDLE, on a request:
  - Hit (valid and tag match):
    - Load: cpu_rdata <= line data. Valid on the next cycle (1-cycle latency).
    - Store: line data <= cpu_wdata; dirty <= 1.
    - hit_count++. stall stays 0. State stays IDLE.
  - Miss:
    - Latch address, wdata and op. stall <= 1. miss_count++.
    - Victim valid and dirty: go to EVICT.
    - Otherwise: go to FILL.
- EVICT:
  - mem_wr=1, mem_addr={victim tag, index}, mem_wdata=victim data.
  - On mem_ack: mem_wr <= 0, go to FILL.
- FILL:
  - mem_rd=1, mem_addr=latched address.
  - On mem_ack: line <= {valid=1, dirty=0, tag, mem_rdata}; mem_rd <= 0; go to DONE.
- DONE (one cycle):
  - Load: cpu_rdata <= filled data.
  - Store: line data <= latched wdata; dirty <= 1.
  - stall <= 0; go to IDLE.
  - cpu_rdata is valid in the first cycle that stall reads 0.

Handshake and timing:
- mem_rd and mem_wr are never both high.
- mem_addr and mem_wdata stay stable while a request is high.
- A mem_ack seen outside EVICT or FILL is ignored.
- Miss latency from the request edge to stall falling:
  - clean miss = 2 + fill wait cycles;
  - dirty miss = 3 + evict wait + fill wait cycles.
- stall rises the cycle after the request edge.

Other rules:
- Counters saturate at all-ones and do not wrap.
- On a miss, the core's inputs may change after the request edge; the latched copies are used.
- Reset in EVICT or FILL: the transaction is abandoned and no line is updated.

Test Plan:
- Load miss on a cold cache: reset, cpu_rd at addr 0x013, memory acks after 3 cycles with 0xDEADBEEF.
  -> stall high for 5 cycles; mem_rd held until ack with mem_addr=0x013; then cpu_rdata=0xDEADBEEF, miss_count=1.
- Load hit: repeat cpu_rd at 0x013.
  -> no stall, no mem_rd; cpu_rdata=0xDEADBEEF the next cycle; hit_count=1.
- Store hit then dirty eviction: cpu_wr 0x013 with data 0x12345678, then cpu_rd 0x023 (same index 3).
  -> first mem_wr with mem_addr=0x013 and mem_wdata=0x12345678, then mem_rd with mem_addr=0x023; no overlap between the two.
- Store miss (write-allocate): cpu_wr 0x105 with data 0xA5A5A5A5; fill returns 0.
  -> after stall drops, cpu_rd 0x105 hits and returns 0xA5A5A5A5; a later conflicting miss on index 5 evicts 0xA5A5A5A5.
- Async reset during FILL: assert rst_n=0 mid-wait without a clock edge.
  -> stall and mem_rd drop immediately; the next cpu_rd 0x013 misses (valid bits cleared); counters=0.
- Both cpu_rd and cpu_wr high on a hit, then 2^CNT_W+2 hits.
  -> treated as a store (dirty set); hit_count saturates at 0xFFFF.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// One 32-bit word per line. Misses go through EVICT (dirty victim only),
// then FILL, then a single DONE cycle that finishes the load or store.
//
// Backing-memory handshake: mem_rd / mem_wr are a request level. Once
// raised, the request stays high with mem_addr / mem_wdata held stable
// until the cycle mem_ack is sampled high. mem_ack is a one-cycle pulse
// that completes the request; mem_rdata is valid alongside it. At most one
// of mem_rd / mem_wr is high at any time. An ack outside EVICT/FILL is ignored.
module dcache_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [1:0]        o_dbg_state
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVICT = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Control state
  logic [1:0]        r_state;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic              r_stall;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_cpu_rdata;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;

  // Copy of the missing request; the core may change its outputs meanwhile
  logic [ADDR_W-1:0] r_lat_addr;
  logic [31:0]       r_lat_wdata;
  logic              r_lat_wr;

  // Line storage without reset; r_valid alone decides whether a line is live
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES];

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_lat_idx;
  logic [TAG_W-1:0]   w_lat_tag;
  logic               w_req;
  logic               w_hit;
  logic               w_data_we;
  logic               w_tag_we;
  logic [INDEX_W-1:0] w_wr_idx;
  logic [31:0]        w_wr_data;

  assign w_idx     = cpu_addr[INDEX_W-1:0];
  assign w_tag     = cpu_addr[ADDR_W-1:INDEX_W];
  assign w_lat_idx = r_lat_addr[INDEX_W-1:0];
  assign w_lat_tag = r_lat_addr[ADDR_W-1:INDEX_W];
  assign w_req     = cpu_rd | cpu_wr;
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign cpu_rdata   = r_cpu_rdata;
  assign stall       = r_stall;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;
  assign o_dbg_state = r_state;

  // Select which line word/tag is written this cycle, if any
  always_comb begin
    w_data_we = 1'b0;
    w_tag_we  = 1'b0;
    w_wr_idx  = w_lat_idx;
    w_wr_data = r_lat_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_hit && cpu_wr) begin
          w_data_we = 1'b1;
          w_wr_idx  = w_idx;
          w_wr_data = cpu_wdata;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          w_data_we = 1'b1;
          w_tag_we  = 1'b1;
          w_wr_data = mem_rdata;
        end
      end
      S_DONE: begin
        if (r_lat_wr) begin
          w_data_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Tag and data array writes
  always_ff @(posedge clk) begin
    if (w_data_we) r_data[w_wr_idx] <= w_wr_data;
    if (w_tag_we)  r_tag[w_wr_idx]  <= w_lat_tag;
  end

  // Miss-handling FSM, line status bits, memory requests and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_stall      <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_lat_addr   <= '0;
      r_lat_wdata  <= '0;
      r_lat_wr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (r_hit_count != {CNT_W{1'b1}}) r_hit_count <= r_hit_count + CNT_W'(1);
              if (cpu_wr) r_dirty[w_idx] <= 1'b1;
              else        r_cpu_rdata    <= r_data[w_idx];
            end else begin
              if (r_miss_count != {CNT_W{1'b1}}) r_miss_count <= r_miss_count + CNT_W'(1);
              r_lat_addr  <= cpu_addr;
              r_lat_wdata <= cpu_wdata;
              r_lat_wr    <= cpu_wr;
              r_stall     <= 1'b1;
              if (r_valid[w_idx] && r_dirty[w_idx]) begin
                r_state     <= S_EVICT;
                r_mem_wr    <= 1'b1;
                r_mem_addr  <= {r_tag[w_idx], w_idx};
                r_mem_wdata <= r_data[w_idx];
              end else begin
                r_state    <= S_FILL;
                r_mem_rd   <= 1'b1;
                r_mem_addr <= cpu_addr;
              end
            end
          end
        end
        S_EVICT: begin
          if (mem_ack) begin
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_lat_addr;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_mem_rd           <= 1'b0;
            r_valid[w_lat_idx] <= 1'b1;
            r_dirty[w_lat_idx] <= 1'b0;
            r_state            <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_lat_wr) r_dirty[w_lat_idx] <= 1'b1;
          else          r_cpu_rdata        <= r_data[w_lat_idx];
          r_stall <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a backing-memory responder with programmable ack
// delay, and a reference model that treats the cache as transparent memory
// (arch_mem) plus a record of which word each index currently holds.
module tb_dcache_ctrl;

  localparam int ADDR_W  = 12;
  localparam int INDEX_W = 4;
  localparam int CNT_W   = 16;
  localparam int LINES   = 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [31:0]       cpu_rdata;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  logic [1:0]        dbg_state;

  logic r_resp_ack  = 1'b0;
  logic r_stray_ack = 1'b0;
  assign mem_ack = r_resp_ack | r_stray_ack;

  dcache_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count), .o_dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int fixed_wait   = -1;   // >=0 forces the ack delay, -1 picks it at random

  logic [31:0] mem_model [4096];
  logic [31:0] arch_mem  [4096];

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    int          waitc;
  } ev_t;
  ev_t ev_q[$];               // memory transactions observed by the responder
  logic [44:0] exp_q[$];      // expected {wr, addr, data} transactions

  bit          line_ok    [LINES];
  bit          line_dirty [LINES];
  logic [11:0] line_addr  [LINES];
  int          m_hits;
  int          m_misses;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) begin
      line_ok[i]    = 1'b0;
      line_dirty[i] = 1'b0;
      line_addr[i]  = '0;
    end
    m_hits   = 0;
    m_misses = 0;
    // dirty data held only in the cache is lost on reset
    for (int a = 0; a < 4096; a++) arch_mem[a] = mem_model[a];
  endfunction

  function automatic void model_op(input bit wr, input logic [11:0] addr,
                                   input logic [31:0] wdata, output bit hit);
    int idx;
    idx = int'(addr[3:0]);
    exp_q.delete();
    hit = line_ok[idx] && (line_addr[idx] == addr);
    if (hit) m_hits++;
    else begin
      m_misses++;
      if (line_ok[idx] && line_dirty[idx])
        exp_q.push_back({1'b1, line_addr[idx], arch_mem[line_addr[idx]]});
      exp_q.push_back({1'b0, addr, 32'h0});
      line_ok[idx]    = 1'b1;
      line_addr[idx]  = addr;
      line_dirty[idx] = 1'b0;
    end
    if (wr) begin
      arch_mem[addr]  = wdata;
      line_dirty[idx] = 1'b1;
    end
  endfunction

  // Expected stall length: 1 + one cycle per memory transaction + ack waits
  function automatic int exp_lat(input bit hit);
    int s;
    if (hit) return 0;
    s = 1 + exp_q.size();
    foreach (ev_q[i]) s += ev_q[i].waitc;
    return s;
  endfunction

  // ---------------- backing memory responder ----------------
  initial begin : responder
    int cnt;
    int cur_wait;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    cnt = 0; cur_wait = 0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      r_resp_ack = 1'b0;
      if (!rst_n) cnt = 0;
      else if (mem_rd || mem_wr) begin
        tests_run++;
        if (mem_rd && mem_wr) begin
          tests_failed++;
          $display("FAIL mem_overlap: mem_rd=%0b mem_wr=%0b, required not both high", mem_rd, mem_wr);
        end
        if (cnt == 0) begin
          cur_wait  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 4));
          req_addr  = mem_addr;
          req_wdata = mem_wdata;
        end else begin
          tests_run++;
          if (mem_addr !== req_addr || (mem_wr && mem_wdata !== req_wdata)) begin
            tests_failed++;
            $display("FAIL mem_stable: addr=%h wdata=%h, required addr=%h wdata=%h",
                     mem_addr, mem_wdata, req_addr, req_wdata);
          end
        end
        if (cnt >= cur_wait) begin
          r_resp_ack = 1'b1;
          ev_q.push_back('{mem_wr, mem_addr, (mem_wr ? mem_wdata : mem_model[mem_addr]), cur_wait});
          if (mem_wr) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic access(input bit rd, input bit wr, input logic [11:0] addr,
                        input logic [31:0] wdata, output int n, output logic [31:0] rdata);
    @(negedge clk);
    ev_q.delete();
    cpu_addr = addr; cpu_wdata = wdata; cpu_rd = rd; cpu_wr = wr;
    @(posedge clk);
    #1;
    // scramble the inputs: a miss must work from its latched copy
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 12'($urandom); cpu_wdata = $urandom;
    @(negedge clk);
    n = 0;
    while (stall === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
    rdata = cpu_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b, required 0", stall); end
    tests_run++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: rd=%b wr=%b, required 0 0", mem_rd, mem_wr); end
    tests_run++; if (cpu_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h, required 0", cpu_rdata); end
    tests_run++; if (mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0 0", mem_addr, mem_wdata); end
    tests_run++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin tests_failed++; $display("FAIL reset_counts: hit=%0d miss=%0d, required 0 0", hit_count, miss_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    bit hit; int n; logic [31:0] got;
    fixed_wait = 3;
    model_op(1'b0, 12'h013, 32'h0, hit);
    access(1'b1, 1'b0, 12'h013, 32'h0, n, got);
    tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL cold_stall_len: got %0d, required 5", n); end
    tests_run++; if (got !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL cold_rdata: got %h, required deadbeef", got); end
    tests_run++;
    if (ev_q.size() != 1 || ev_q[0].wr || ev_q[0].addr !== 12'h013) begin
      tests_failed++; $display("FAIL cold_fill: %0d transactions, required one fill at 013", ev_q.size());
    end
    tests_run++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin tests_failed++; $display("FAIL cold_counts: hit=%0d miss=%0d, required 0 1", hit_count, miss_count); end
  endtask

  task automatic test_load_hit();
    bit hit; int n; logic [31:0] got;
    model_op(1'b0, 12'h013, 32'h0, hit);
    access(1'b1, 1'b0, 12'h013, 32'h0, n, got);
    tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL hit_stall: got %0d, required 0", n); end
    tests_run++; if (got !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL hit_rdata: got %h, required deadbeef", got); end
    tests_run++; if (ev_q.size() != 0) begin tests_failed++; $display("FAIL hit_no_mem: got %0d transactions, required 0", ev_q.size()); end
    tests_run++; if (hit_count !== 16'd1) begin tests_failed++; $display("FAIL hit_count: got %0d, required 1", hit_count); end
  endtask

  task automatic test_store_evict();
    bit hit; int n; logic [31:0] got;
    fixed_wait = 2;
    model_op(1'b1, 12'h013, 32'h12345678, hit);
    access(1'b0, 1'b1, 12'h013, 32'h12345678, n, got);
    tests_run++; if (n !== 0 || hit_count !== 16'd2) begin tests_failed++; $display("FAIL store_hit: stall=%0d hit=%0d, required 0 2", n, hit_count); end
    model_op(1'b0, 12'h023, 32'h0, hit);
    access(1'b1, 1'b0, 12'h023, 32'h0, n, got);
    tests_run++;
    if (ev_q.size() != 2 || !ev_q[0].wr || ev_q[0].addr !== 12'h013 || ev_q[0].data !== 32'h12345678 ||
        ev_q[1].wr || ev_q[1].addr !== 12'h023) begin
      tests_failed++; $display("FAIL evict_seq: %0d transactions, required wb 013/12345678 then fill 023", ev_q.size());
    end
    tests_run++; if (n !== 7) begin tests_failed++; $display("FAIL evict_stall_len: got %0d, required 7", n); end
    tests_run++; if (got !== arch_mem[12'h023]) begin tests_failed++; $display("FAIL evict_rdata: got %h, required %h", got, arch_mem[12'h023]); end
    tests_run++; if (miss_count !== 16'd2) begin tests_failed++; $display("FAIL evict_miss_count: got %0d, required 2", miss_count); end
  endtask

  task automatic test_store_miss();
    bit hit; int n; logic [31:0] got;
    fixed_wait = -1;
    model_op(1'b1, 12'h105, 32'hA5A5A5A5, hit);
    access(1'b0, 1'b1, 12'h105, 32'hA5A5A5A5, n, got);
    tests_run++; if (n !== exp_lat(hit)) begin tests_failed++; $display("FAIL smiss_stall_len: got %0d, required %0d", n, exp_lat(hit)); end
    tests_run++; if (ev_q.size() != 1 || ev_q[0].wr || ev_q[0].addr !== 12'h105) begin tests_failed++; $display("FAIL smiss_fill: %0d transactions, required one fill at 105", ev_q.size()); end
    model_op(1'b0, 12'h105, 32'h0, hit);
    access(1'b1, 1'b0, 12'h105, 32'h0, n, got);
    tests_run++; if (n !== 0 || got !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL smiss_readback: stall=%0d data=%h, required 0 a5a5a5a5", n, got); end
    model_op(1'b0, 12'h205, 32'h0, hit);
    access(1'b1, 1'b0, 12'h205, 32'h0, n, got);
    tests_run++;
    if (ev_q.size() != 2 || !ev_q[0].wr || ev_q[0].addr !== 12'h105 || ev_q[0].data !== 32'hA5A5A5A5) begin
      tests_failed++; $display("FAIL smiss_evict: %0d transactions, required wb 105/a5a5a5a5 first", ev_q.size());
    end
    tests_run++; if (got !== arch_mem[12'h205]) begin tests_failed++; $display("FAIL smiss_conflict_rdata: got %h, required %h", got, arch_mem[12'h205]); end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    #1 r_stray_ack = 1'b1;
    @(posedge clk);
    #1 r_stray_ack = 1'b0;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      tests_failed++; $display("FAIL stray_ack: stall=%b rd=%b wr=%b, required 0 0 0", stall, mem_rd, mem_wr);
    end
    tests_run++;
    if (hit_count !== 16'(sat(m_hits)) || miss_count !== 16'(sat(m_misses))) begin
      tests_failed++; $display("FAIL stray_counts: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count, sat(m_hits), sat(m_misses));
    end
  endtask

  task automatic test_back_to_back();
    bit hit, wr, rd; int n, en; logic [31:0] got, d; logic [11:0] a;
    fixed_wait = -1;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      a  = {8'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      d  = $urandom;
      model_op(wr, a, d, hit);
      access(rd, wr, a, d, n, got);
      en = exp_lat(hit);
      tests_run++; if (n !== en) begin tests_failed++; $display("FAIL rnd_stall_len[%0d]: addr=%h got %0d, required %0d", i, a, n, en); end
      if (!wr) begin
        tests_run++; if (got !== arch_mem[a]) begin tests_failed++; $display("FAIL rnd_rdata[%0d]: addr=%h got %h, required %h", i, a, got, arch_mem[a]); end
      end
      tests_run++;
      if (ev_q.size() != exp_q.size()) begin
        tests_failed++; $display("FAIL rnd_mem_count[%0d]: got %0d transactions, required %0d", i, ev_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          if (ev_q[k].wr !== exp_q[k][44] || ev_q[k].addr !== exp_q[k][43:32] ||
              (exp_q[k][44] && ev_q[k].data !== exp_q[k][31:0])) begin
            tests_failed++;
            $display("FAIL rnd_mem_txn[%0d.%0d]: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     i, k, ev_q[k].wr, ev_q[k].addr, ev_q[k].data, exp_q[k][44], exp_q[k][43:32], exp_q[k][31:0]);
            break;
          end
        end
      end
      tests_run++;
      if (hit_count !== 16'(sat(m_hits)) || miss_count !== 16'(sat(m_misses))) begin
        tests_failed++; $display("FAIL rnd_counts[%0d]: hit=%0d miss=%0d, required %0d %0d", i, hit_count, miss_count, sat(m_hits), sat(m_misses));
      end
    end
  endtask

  task automatic test_reset_fill();
    bit hit; int n; logic [31:0] got;
    fixed_wait = 1000;
    @(negedge clk);
    cpu_addr = 12'hFF9; cpu_rd = 1'b1;
    @(posedge clk);
    #1 cpu_rd = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (stall !== 1'b1 || mem_rd !== 1'b1) begin tests_failed++; $display("FAIL rfill_pending: stall=%b rd=%b, required 1 1", stall, mem_rd); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (stall !== 1'b0 || mem_rd !== 1'b0) begin tests_failed++; $display("FAIL rfill_async_drop: stall=%b rd=%b, required 0 0", stall, mem_rd); end
    tests_run++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin tests_failed++; $display("FAIL rfill_counts: hit=%0d miss=%0d, required 0 0", hit_count, miss_count); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fixed_wait = -1;
    model_op(1'b0, 12'h013, 32'h0, hit);
    access(1'b1, 1'b0, 12'h013, 32'h0, n, got);
    tests_run++; if (n !== exp_lat(hit) || ev_q.size() != 1) begin tests_failed++; $display("FAIL rfill_remiss: stall=%0d txns=%0d, required %0d 1", n, ev_q.size(), exp_lat(hit)); end
    tests_run++; if (got !== arch_mem[12'h013]) begin tests_failed++; $display("FAIL rfill_rdata: got %h, required %h", got, arch_mem[12'h013]); end
    tests_run++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin tests_failed++; $display("FAIL rfill_after_counts: hit=%0d miss=%0d, required 0 1", hit_count, miss_count); end
  endtask

  task automatic test_both_saturate();
    bit hit; int n; logic [31:0] got;
    model_op(1'b0, 12'h044, 32'h0, hit);
    access(1'b1, 1'b0, 12'h044, 32'h0, n, got);
    model_op(1'b1, 12'h044, 32'h0BADF00D, hit);
    access(1'b1, 1'b1, 12'h044, 32'h0BADF00D, n, got);
    tests_run++; if (n !== 0 || hit_count !== 16'(sat(m_hits))) begin tests_failed++; $display("FAIL both_hit: stall=%0d hit=%0d, required 0 %0d", n, hit_count, sat(m_hits)); end
    model_op(1'b0, 12'h144, 32'h0, hit);
    access(1'b1, 1'b0, 12'h144, 32'h0, n, got);
    tests_run++;
    if (ev_q.size() != 2 || !ev_q[0].wr || ev_q[0].addr !== 12'h044 || ev_q[0].data !== 32'h0BADF00D) begin
      tests_failed++; $display("FAIL both_is_store: %0d transactions, required wb 044/0badf00d first", ev_q.size());
    end
    @(negedge clk);
    cpu_addr = 12'h144; cpu_rd = 1'b1;
    repeat (65538) @(posedge clk);
    #1 cpu_rd = 1'b0;
    m_hits += 65538;
    @(negedge clk);
    tests_run++; if (hit_count !== 16'hFFFF) begin tests_failed++; $display("FAIL hit_saturate: got %h, required ffff", hit_count); end
    tests_run++; if (miss_count !== 16'(sat(m_misses)) || stall !== 1'b0) begin tests_failed++; $display("FAIL sat_side: miss=%0d stall=%b, required %0d 0", miss_count, stall, sat(m_misses)); end
    tests_run++; if (cpu_rdata !== arch_mem[12'h144]) begin tests_failed++; $display("FAIL sat_rdata: got %h, required %h", cpu_rdata, arch_mem[12'h144]); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    for (int a = 0; a < 4096; a++) mem_model[a] = $urandom;
    mem_model[12'h013] = 32'hDEADBEEF;
    mem_model[12'h105] = 32'h0;
    model_reset();
    test_reset();
    test_cold_miss();
    test_load_hit();
    test_store_evict();
    test_store_miss();
    test_stray_ack();
    test_back_to_back();
    test_reset_fill();
    test_both_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
